// File: rtl/ex_div_ctrl.sv
// ---------------------------------------------------------------------------
// ex_div_ctrl
//
// Multi-cycle integer divide controller for the EX stage. A div/mod request
// from the instruction in EX is latched into private operand registers, then
// a 32-iteration restoring division runs on its own shift/subtract datapath.
// EX ready-go is held low until the fixed-up quotient or remainder is
// registered on div_result.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-high; forces IDLE, zero counter/result
//   div_req      EX holds a valid div/mod instruction
//   div_op       00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu (sampled at start)
//   div_src1     dividend (sampled at start)
//   div_src2     divisor  (sampled at start)
//   out_accept   EX instruction moves to ME this cycle
//   cancel       flush of the EX instruction (highest priority)
//   ex_ready_go  ~div_req | DONE (combinational)
//   div_busy     high while iterating
//   div_result   registered quotient or remainder, valid in DONE
// ---------------------------------------------------------------------------
module ex_div_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_req,
  input  logic [1:0]  div_op,
  input  logic [31:0] div_src1,
  input  logic [31:0] div_src2,
  input  logic        out_accept,
  input  logic        cancel,
  output logic        ex_ready_go,
  output logic        div_busy,
  output logic [31:0] div_result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [4:0]  counter_reg;
  logic [1:0]  op_reg;
  logic        sign1_reg;
  logic        sign2_reg;
  logic [31:0] dvs_reg;   // divisor magnitude
  logic [31:0] rem_reg;   // partial remainder
  logic [31:0] quo_reg;   // dividend bits shifting out, quotient bits shifting in

  logic        start;
  logic        last_step;
  logic        is_signed_op;
  logic [31:0] abs_src1;
  logic [31:0] abs_src2;

  logic [32:0] shifted;
  logic [32:0] trial;
  logic        trial_neg;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic        neg_quo;
  logic        neg_rem;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] result_fix;

  // ------------------------------------------------------------------
  // Start decode and operand magnitudes
  // ------------------------------------------------------------------
  assign start        = (state_reg == S_IDLE) && div_req && !cancel;
  assign last_step    = (state_reg == S_BUSY) && (counter_reg == 5'd31);
  assign is_signed_op = ~div_op[1];

  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  assign abs_src1 = (is_signed_op && div_src1[31]) ? (32'd0 - div_src1) : div_src1;
  assign abs_src2 = (is_signed_op && div_src2[31]) ? (32'd0 - div_src2) : div_src2;

  // ------------------------------------------------------------------
  // One restoring-division step
  // ------------------------------------------------------------------
  // The partial remainder is always below the divisor, so the shifted value
  // is below twice the divisor and a 33-bit trial subtract has a reliable
  // sign bit. A zero divisor makes every trial succeed, yielding an all-ones
  // quotient and the dividend as remainder.
  assign shifted   = {rem_reg, quo_reg[31]};
  assign trial     = shifted - {1'b0, dvs_reg};
  assign trial_neg = trial[32];
  assign rem_step  = trial_neg ? shifted[31:0] : trial[31:0];
  assign quo_step  = {quo_reg[30:0], ~trial_neg};

  // ------------------------------------------------------------------
  // Sign fix-up on the final step's values
  // ------------------------------------------------------------------
  assign neg_quo    = ~op_reg[1] & (sign1_reg ^ sign2_reg);
  assign neg_rem    = ~op_reg[1] & sign1_reg;
  assign quo_fix    = neg_quo ? (32'd0 - quo_step) : quo_step;
  assign rem_fix    = neg_rem ? (32'd0 - rem_step) : rem_step;
  assign result_fix = op_reg[0] ? rem_fix : quo_fix;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (cancel) begin
      // Flush wins over completion, acceptance and a new start.
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (div_req) begin
            state_next = S_BUSY;
          end
        end
        S_BUSY: begin
          // div_req dropping here is a protocol error; finish anyway.
          if (counter_reg == 5'd31) begin
            state_next = S_DONE;
          end
        end
        S_DONE: begin
          if (out_accept) begin
            state_next = S_IDLE;
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // FSM: outputs
  // ------------------------------------------------------------------
  always_comb begin
    div_busy    = (state_reg == S_BUSY);
    ex_ready_go = ~div_req | (state_reg == S_DONE);
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_reg <= 5'd0;
      op_reg      <= 2'd0;
      sign1_reg   <= 1'b0;
      sign2_reg   <= 1'b0;
      dvs_reg     <= 32'd0;
      rem_reg     <= 32'd0;
      quo_reg     <= 32'd0;
    end else if (start) begin
      counter_reg <= 5'd0;
      op_reg      <= div_op;
      sign1_reg   <= div_src1[31];
      sign2_reg   <= div_src2[31];
      dvs_reg     <= abs_src2;
      rem_reg     <= 32'd0;
      quo_reg     <= abs_src1;
    end else if ((state_reg == S_BUSY) && !cancel) begin
      counter_reg <= counter_reg + 5'd1;
      rem_reg     <= rem_step;
      quo_reg     <= quo_step;
    end
  end

  // Result only changes on a completed, non-cancelled division, so no
  // partial value is ever visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_result <= 32'd0;
    end else if (last_step && !cancel) begin
      div_result <= result_fix;
    end
  end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ex_div_ctrl
//
// Drives directed and random divide requests into ex_div_ctrl and compares
// latency, handshake outputs and results against an arithmetic reference.
// ---------------------------------------------------------------------------
module tb_ex_div_ctrl;

  logic        clk;
  logic        reset;
  logic        div_req;
  logic [1:0]  div_op;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        out_accept;
  logic        cancel;
  logic        ex_ready_go;
  logic        div_busy;
  logic [31:0] div_result;

  int          n_checks;
  int          n_fail;
  logic [31:0] last_result;

  ex_div_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .div_req     (div_req),
    .div_op      (div_op),
    .div_src1    (div_src1),
    .div_src2    (div_src2),
    .out_accept  (out_accept),
    .cancel      (cancel),
    .ex_ready_go (ex_ready_go),
    .div_busy    (div_busy),
    .div_result  (div_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic with the documented corner cases.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    if (!op[1]) begin
      if (b == 32'd0) begin
        // magnitude result 0xFFFFFFFF / |a|, then sign fix-up
        q = a[31] ? 32'd1 : 32'hFFFF_FFFF;
        r = a;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      if (b == 32'd0) begin
        q = 32'hFFFF_FFFF;
        r = a;
      end else begin
        q = a / b;
        r = a % b;
      end
    end
    return op[0] ? r : q;
  endfunction

  // Called at a negedge. Issues a request, checks the 33-cycle latency and the
  // result, holds DONE for hold_cycles, then raises out_accept and returns in
  // cycle D. With cancel_at > 0 the request is flushed at T+cancel_at and the
  // task returns at T+cancel_at+1 with div_req still high.
  task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold_cycles, input int cancel_at);
    logic [31:0] exp;
    int          n;
    bit          done;
    exp        = ref_div(op, a, b);
    div_req    = 1'b1;
    div_op     = op;
    div_src1   = a;
    div_src2   = b;
    out_accept = 1'b0;
    cancel     = 1'b0;
    #1;
    check("start_ready_go", {31'd0, ex_ready_go}, 32'd0);
    check("start_busy", {31'd0, div_busy}, 32'd0);
    done = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      #1;
      if (cancel) begin
        cancel = 1'b0;
        check("cancel_busy", {31'd0, div_busy}, 32'd0);
        check("cancel_result", div_result, last_result);
        $display("cancel op=%0d a=%h b=%h at T+%0d", op, a, b, cancel_at);
        return;
      end
      if (n == 1) begin
        check("busy_first", {31'd0, div_busy}, 32'd1);
        // operands after the start cycle must be ignored
        div_op   = 2'($urandom);
        div_src1 = $urandom;
        div_src2 = $urandom;
      end
      if (cancel_at != 0 && n == cancel_at) begin
        cancel = 1'b1;
      end else if (ex_ready_go) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) n = 41;
    check("latency", n, 32'd33);
    check("result", div_result, exp);
    check("done_busy", {31'd0, div_busy}, 32'd0);
    $display("div op=%0d a=%h b=%h result=%h expected=%h latency=%0d",
             op, a, b, div_result, exp, n);
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      #1;
      check("hold_result", div_result, exp);
      check("hold_ready_go", {31'd0, ex_ready_go}, 32'd1);
    end
    last_result = exp;
    out_accept  = 1'b1;
  endtask

  // Called at a negedge: no divide instruction in EX.
  task automatic go_idle();
    div_req    = 1'b0;
    out_accept = 1'b0;
    cancel     = 1'b0;
    #1;
    check("idle_ready_go", {31'd0, ex_ready_go}, 32'd1);
    check("idle_busy", {31'd0, div_busy}, 32'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    n_checks    = 0;
    n_fail      = 0;
    last_result = 32'd0;
    reset       = 1'b1;
    div_req     = 1'b0;
    div_op      = 2'd0;
    div_src1    = 32'd0;
    div_src2    = 32'd0;
    out_accept  = 1'b0;
    cancel      = 1'b0;

    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_busy", {31'd0, div_busy}, 32'd0);
    check("reset_result", div_result, 32'd0);
    check("reset_ready_go", {31'd0, ex_ready_go}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // directed cases, back to back (each new request one cycle after accept)
    @(negedge clk); run_div(2'd0, 32'd100, 32'd7, 10, 0);
    @(negedge clk); run_div(2'd1, 32'hFFFF_FFF9, 32'd3, 0, 0);
    @(negedge clk); run_div(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    @(negedge clk); run_div(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    @(negedge clk); run_div(2'd2, 32'hFFFF_FFFF, 32'd2, 0, 0);
    @(negedge clk); run_div(2'd3, 32'h1234_5678, 32'd0, 0, 0);
    @(negedge clk); run_div(2'd2, 32'hDEAD_BEEF, 32'd0, 0, 0);
    @(negedge clk); run_div(2'd0, 32'hFFFF_FF00, 32'd0, 0, 0);
    @(negedge clk); run_div(2'd1, 32'hFFFF_FF00, 32'd0, 1, 0);
    @(negedge clk); go_idle();

    // cancel at T+10, new request at T+11
    @(negedge clk); run_div(2'd0, 32'd1000, 32'd3, 0, 10);
    run_div(2'd3, 32'd1000, 32'd7, 0, 0);
    @(negedge clk); go_idle();

    // random requests
    for (int k = 0; k < 20; k++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      @(negedge clk);
      run_div(rop, ra, rb, $urandom_range(0, 3), 0);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk); go_idle();
      end
    end
    @(negedge clk); go_idle();

    // asynchronous reset at T+20, between edges
    @(negedge clk);
    div_req  = 1'b1;
    div_op   = 2'd0;
    div_src1 = 32'd12345;
    div_src2 = 32'd17;
    for (int i = 0; i < 20; i++) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("areset_busy", {31'd0, div_busy}, 32'd0);
    check("areset_result", div_result, 32'd0);
    last_result = 32'd0;
    @(negedge clk);
    reset   = 1'b0;
    div_req = 1'b0;
    #1;
    check("post_reset_ready_go", {31'd0, ex_ready_go}, 32'd1);

    @(negedge clk); run_div(2'd0, 32'hFFFF_FF9C, 32'd7, 0, 0);
    @(negedge clk); go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
